// File: rtl/vmem_xbar_pkg.sv
// Shared crossbar geometry helpers and state encoding, used by the store-side
// crossbar and its per-slot arbiter (and mirrored by the load-side crossbar).
package vmem_xbar_pkg;

  localparam int DEF_MEMWIDTH      = 128;
  localparam int DEF_LOG2MEMWIDTH  = 7;
  localparam int DEF_NUMLANES      = 16;
  localparam int DEF_LANEWIDTH     = 8;
  localparam int DEF_LOG2LANEWIDTH = 3;
  localparam int DEF_NUMSLOTS      = DEF_MEMWIDTH / DEF_LANEWIDTH;
  localparam int DEF_SELWIDTH      = DEF_LOG2MEMWIDTH - DEF_LOG2LANEWIDTH;

  function automatic int xbar_numslots(input int memwidth, input int lanewidth);
    return memwidth / lanewidth;
  endfunction

  function automatic int xbar_selwidth(input int log2memwidth, input int log2lanewidth);
    return log2memwidth - log2lanewidth;
  endfunction

  // Bit offset of a slot (or lane element) inside a packed line.
  function automatic int xbar_field_lsb(input int index, input int fieldwidth);
    return index * fieldwidth;
  endfunction

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } xbar_state_e;

endpackage

// File: rtl/vmem_slot_arbiter.sv
// Per-slot lane picker: lowest-index matching lane with VMEM_STORE_XBAR_SERIALIZE_EN,
// otherwise highest-index matching lane (last store wins in a single beat).
module vmem_slot_arbiter
  import vmem_xbar_pkg::*;
#(
  parameter int NUMLANES  = DEF_NUMLANES,
  parameter int LANEWIDTH = DEF_LANEWIDTH,
  parameter int SELWIDTH  = DEF_SELWIDTH,
  parameter int SLOT      = 0
) (
  input  logic [NUMLANES-1:0]           lane_en_i,
  input  logic [SELWIDTH*NUMLANES-1:0]  lane_sel_i,
  input  logic [LANEWIDTH*NUMLANES-1:0] lane_data_i,
  output logic                          win_valid_o,
  output logic [NUMLANES-1:0]           win_onehot_o,
  output logic [LANEWIDTH-1:0]          win_data_o
);

  logic [NUMLANES-1:0] match;

  generate
    for (genvar gi = 0; gi < NUMLANES; gi++) begin : g_match
      assign match[gi] = lane_en_i[gi] &&
                         (lane_sel_i[xbar_field_lsb(gi, SELWIDTH) +: SELWIDTH] == SELWIDTH'(SLOT));
    end
  endgenerate

  assign win_valid_o = |match;

  always_comb begin
    win_onehot_o = '0;
    win_data_o   = '0;
`ifdef VMEM_STORE_XBAR_SERIALIZE_EN
    // Scan downwards so the lowest matching lane is the last one written.
    for (int i = NUMLANES - 1; i >= 0; i--) begin
      if (match[i]) begin
        win_onehot_o    = '0;
        win_onehot_o[i] = 1'b1;
        win_data_o      = lane_data_i[i*LANEWIDTH +: LANEWIDTH];
      end
    end
`else
    for (int i = 0; i < NUMLANES; i++) begin
      if (match[i]) begin
        win_onehot_o    = '0;
        win_onehot_o[i] = 1'b1;
        win_data_o      = lane_data_i[i*LANEWIDTH +: LANEWIDTH];
      end
    end
`endif
  end

endmodule

// File: rtl/vmem_store_crossbar.sv
// Store-direction lane-to-slot crossbar. Define VMEM_STORE_XBAR_SERIALIZE_EN to
// serialize slot conflicts over several beats; otherwise the highest lane wins in one beat.
module vmem_store_crossbar
  import vmem_xbar_pkg::*;
#(
  parameter int MEMWIDTH      = DEF_MEMWIDTH,
  parameter int LOG2MEMWIDTH  = DEF_LOG2MEMWIDTH,
  parameter int NUMLANES      = DEF_NUMLANES,
  parameter int LANEWIDTH     = DEF_LANEWIDTH,
  parameter int LOG2LANEWIDTH = DEF_LOG2LANEWIDTH
) (
  input  logic                                               clk,
  input  logic                                               resetn,
  input  logic                                               in_valid,
  output logic                                               in_ready,
  input  logic [NUMLANES-1:0]                                in_en,
  input  logic [(LOG2MEMWIDTH-LOG2LANEWIDTH)*NUMLANES-1:0]   in_sel,
  input  logic [LANEWIDTH*NUMLANES-1:0]                      in_data,
  output logic                                               out_valid,
  input  logic                                               out_ready,
  output logic [MEMWIDTH-1:0]                                out_data,
  output logic [MEMWIDTH/LANEWIDTH-1:0]                      out_we,
  output logic                                               out_last,
  output logic                                               busy
);

  localparam int SEL_W   = xbar_selwidth(LOG2MEMWIDTH, LOG2LANEWIDTH);
  localparam int N_SLOTS = xbar_numslots(MEMWIDTH, LANEWIDTH);

  xbar_state_e state_q, state_d;

  logic [NUMLANES-1:0]           pend_en_q, pend_en_d;
  logic [SEL_W*NUMLANES-1:0]     pend_sel_q, pend_sel_d;
  logic [LANEWIDTH*NUMLANES-1:0] pend_data_q, pend_data_d;

  logic                          out_valid_q, out_valid_d;
  logic [MEMWIDTH-1:0]           out_data_q, out_data_d;
  logic [N_SLOTS-1:0]            out_we_q, out_we_d;
  logic                          out_last_q, out_last_d;

  logic                          slot_valid  [N_SLOTS];
  logic [NUMLANES-1:0]           slot_onehot [N_SLOTS];
  logic [LANEWIDTH-1:0]          slot_data   [N_SLOTS];

  logic [MEMWIDTH-1:0]           beat_data;
  logic [N_SLOTS-1:0]            beat_we;
  logic [NUMLANES-1:0]           issued;
  logic [NUMLANES-1:0]           remaining;
  logic                          beat_last;
  logic                          beat_load;
  logic                          accept;

  generate
    for (genvar gi = 0; gi < N_SLOTS; gi++) begin : g_slot
      vmem_slot_arbiter #(
        .NUMLANES  (NUMLANES),
        .LANEWIDTH (LANEWIDTH),
        .SELWIDTH  (SEL_W),
        .SLOT      (gi)
      ) u_arb (
        .lane_en_i    (pend_en_q),
        .lane_sel_i   (pend_sel_q),
        .lane_data_i  (pend_data_q),
        .win_valid_o  (slot_valid[gi]),
        .win_onehot_o (slot_onehot[gi]),
        .win_data_o   (slot_data[gi])
      );
      assign beat_data[xbar_field_lsb(gi, LANEWIDTH) +: LANEWIDTH] = slot_data[gi];
      assign beat_we[gi] = slot_valid[gi];
    end
  endgenerate

  // Lanes carried by this beat; in single-beat mode every pending lane retires,
  // including the losers that were overwritten by a higher lane.
  always_comb begin
    issued = '0;
    for (int s = 0; s < N_SLOTS; s++) begin
      issued = issued | slot_onehot[s];
    end
`ifndef VMEM_STORE_XBAR_SERIALIZE_EN
    issued = issued | pend_en_q;
`endif
  end

  assign remaining = pend_en_q & ~issued;
  assign beat_last = (remaining == '0);
  assign beat_load = (state_q == ST_ISSUE) && (!out_valid_q || out_ready);
  assign in_ready  = (state_q == ST_IDLE) || (beat_load && beat_last);
  assign accept    = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept && (in_en != '0)) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (beat_load && beat_last) begin
          state_d = (accept && (in_en != '0)) ? ST_ISSUE : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    pend_en_d   = pend_en_q;
    pend_sel_d  = pend_sel_q;
    pend_data_d = pend_data_q;
    if (accept) begin
      pend_en_d   = in_en;
      pend_sel_d  = in_sel;
      pend_data_d = in_data;
    end else if (beat_load) begin
      pend_en_d   = remaining;
    end
  end

  // Output register only moves on a load or a completed handshake, so a
  // stalled beat stays frozen.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_we_d    = out_we_q;
    out_last_d  = out_last_q;
    if (beat_load) begin
      out_valid_d = 1'b1;
      out_data_d  = beat_data;
      out_we_d    = beat_we;
      out_last_d  = beat_last;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      pend_en_q   <= '0;
      pend_sel_q  <= '0;
      pend_data_q <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_we_q    <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_en_q   <= pend_en_d;
      pend_sel_q  <= pend_sel_d;
      pend_data_q <= pend_data_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_we_q    <= out_we_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_we    = out_we_q;
  assign out_last  = out_last_q;
  assign busy      = (state_q == ST_ISSUE) || out_valid_q;

endmodule

// File: tb/tb_vmem_store_crossbar.sv
// Scoreboard bench for vmem_store_crossbar: directed scenarios plus randomized traffic
// against a lane-order store model.
module tb_vmem_store_crossbar;

  localparam int NL = 16;
  localparam int LW = 8;
  localparam int SW = 4;
  localparam int NS = 16;
  localparam int MW = 128;

  typedef struct packed {
    logic [MW-1:0] data;
    logic [NS-1:0] we;
    logic          last;
  } beat_t;

  logic             clk = 1'b0;
  logic             resetn;
  logic             in_valid;
  logic             in_ready;
  logic [NL-1:0]    in_en;
  logic [SW*NL-1:0] in_sel;
  logic [LW*NL-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [MW-1:0]    out_data;
  logic [NS-1:0]    out_we;
  logic             out_last;
  logic             busy;

  vmem_store_crossbar dut (
    .clk       (clk),
    .resetn    (resetn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_en     (in_en),
    .in_sel    (in_sel),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_we    (out_we),
    .out_last  (out_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  int          hs_count = 0;
  int          hs_cyc[$];
  beat_t       exp_q[$];
  logic [LW-1:0] mem_dut [NS];
  logic [LW-1:0] mem_ref [NS];
  int          ready_mode = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ($urandom_range(0, 3) != 0);
      default: out_ready = 1'b0;
    endcase
  end

  task automatic check(input string name, input logic [MW-1:0] act, input logic [MW-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout required=event", name);
  endtask

  // Reference: memory is the result of storing enabled lanes in lane order;
  // beats come from counting, per slot, how many enabled lanes target it.
  task automatic model_push(input logic [NL-1:0] en, input logic [SW*NL-1:0] sel,
                            input logic [LW*NL-1:0] data);
    beat_t b;
    int    cnt[NS];
    int    seen[NS];
    int    nb;
    int    s;
    for (int l = 0; l < NL; l++)
      if (en[l]) mem_ref[sel[l*SW +: SW]] = data[l*LW +: LW];
    if (en == '0) return;
`ifdef VMEM_STORE_XBAR_SERIALIZE_EN
    for (int k = 0; k < NS; k++) cnt[k] = 0;
    nb = 0;
    for (int l = 0; l < NL; l++) begin
      if (en[l]) begin
        s = int'(sel[l*SW +: SW]);
        cnt[s]++;
        if (cnt[s] > nb) nb = cnt[s];
      end
    end
    for (int bi = 0; bi < nb; bi++) begin
      b = '0;
      for (int k = 0; k < NS; k++) seen[k] = 0;
      for (int l = 0; l < NL; l++) begin
        if (en[l]) begin
          s = int'(sel[l*SW +: SW]);
          if (seen[s] == bi) begin
            b.data[s*LW +: LW] = data[l*LW +: LW];
            b.we[s] = 1'b1;
          end
          seen[s]++;
        end
      end
      b.last = (bi == nb - 1);
      exp_q.push_back(b);
    end
`else
    b = '0;
    for (int l = 0; l < NL; l++) begin
      if (en[l]) begin
        s = int'(sel[l*SW +: SW]);
        b.data[s*LW +: LW] = data[l*LW +: LW];
        b.we[s] = 1'b1;
      end
    end
    b.last = 1'b1;
    exp_q.push_back(b);
`endif
  endtask

  // Monitor: pops the scoreboard on every delivered beat and checks hold-under-stall.
  logic          stall_prev = 1'b0;
  logic [MW-1:0] prev_data;
  logic [NS-1:0] prev_we;
  logic          prev_last;
  beat_t         mon_e;

  always @(negedge clk) begin
    if (resetn !== 1'b1) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("hold_valid", MW'(out_valid), MW'(1));
        check("hold_data", out_data, prev_data);
        check("hold_we", MW'(out_we), MW'(prev_we));
        check("hold_last", MW'(out_last), MW'(prev_last));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_beat actual=we:%0h data:%0h required=no_beat", out_we, out_data);
        end else begin
          mon_e = exp_q.pop_front();
          check("beat_data", out_data, mon_e.data);
          check("beat_we", MW'(out_we), MW'(mon_e.we));
          check("beat_last", MW'(out_last), MW'(mon_e.last));
        end
        for (int s = 0; s < NS; s++)
          if (out_we[s]) mem_dut[s] = out_data[s*LW +: LW];
        hs_cyc.push_back(cyc);
        hs_count++;
      end
      stall_prev = out_valid && !out_ready;
      prev_data  = out_data;
      prev_we    = out_we;
      prev_last  = out_last;
    end
  end

  // Drive a request at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [NL-1:0] en, input logic [SW*NL-1:0] sel,
                      input logic [LW*NL-1:0] data, output int acc_cyc);
    bit ok = 0;
    in_en    = en;
    in_sel   = sel;
    in_data  = data;
    in_valid = 1'b1;
    acc_cyc  = -1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        acc_cyc = cyc;
        model_push(en, sel, data);
        break;
      end
      @(posedge clk); #1;
    end
    if (!ok) fail_now("accept_timeout");
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int t = 0; t < 1000; t++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy) begin
        done = 1;
        break;
      end
    end
    if (!done) fail_now("drain_timeout");
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_valid"}, MW'(out_valid), MW'(0));
    check({tag, "_out_data"}, out_data, MW'(0));
    check({tag, "_out_we"}, MW'(out_we), MW'(0));
    check({tag, "_out_last"}, MW'(out_last), MW'(0));
    check({tag, "_in_ready"}, MW'(in_ready), MW'(1));
    check({tag, "_busy"}, MW'(busy), MW'(0));
  endtask

  task automatic clear_mems();
    for (int s = 0; s < NS; s++) begin
      mem_dut[s] = '0;
      mem_ref[s] = '0;
    end
  endtask

  logic [NL-1:0]    id_en, cf_en;
  logic [SW*NL-1:0] id_sel, cf_sel, r_sel;
  logic [LW*NL-1:0] id_data, cf_data, r_data;
  logic [NL-1:0]    r_en;
  logic [MW-1:0]    id_line;
  int               acc_a, acc_b, cnt, hs0, nbefore;
  bit               seen_flag;

  initial begin
    resetn    = 1'b0;
    in_valid  = 1'b0;
    in_en     = '0;
    in_sel    = '0;
    in_data   = '0;
    out_ready = 1'b1;
    clear_mems();

    id_en = '1;
    for (int i = 0; i < NL; i++) begin
      id_sel[i*SW +: SW]  = SW'(i);
      id_data[i*LW +: LW] = LW'(8'h10 + i);
      id_line[i*LW +: LW] = LW'(8'h10 + i);
    end
    cf_en   = '0;
    cf_sel  = {$urandom, $urandom};
    cf_data = {$urandom, $urandom, $urandom, $urandom};
    cf_en[2] = 1'b1; cf_en[5] = 1'b1; cf_en[9] = 1'b1;
    cf_sel[2*SW +: SW] = 4'd3; cf_sel[5*SW +: SW] = 4'd3; cf_sel[9*SW +: SW] = 4'd3;
    cf_data[2*LW +: LW] = 8'hA2; cf_data[5*LW +: LW] = 8'hA5; cf_data[9*LW +: LW] = 8'hA9;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;

    // Identity scatter: pending stage after the accepting edge, beat one edge later.
    send(id_en, id_sel, id_data, acc_a);
    @(negedge clk);
    check("id_pend_valid", MW'(out_valid), MW'(0));
    check("id_pend_busy", MW'(busy), MW'(1));
    @(negedge clk);
    check("id_beat_valid", MW'(out_valid), MW'(1));
    check("id_beat_we", MW'(out_we), MW'(16'hFFFF));
    check("id_beat_data", out_data, id_line);
    check("id_beat_last", MW'(out_last), MW'(1));
    @(posedge clk); #1;
    wait_idle();

    // Three-way conflict on slot 3.
    send(cf_en, cf_sel, cf_data, acc_a);
    cnt = 0;
    seen_flag = 0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (in_ready) begin seen_flag = 1; break; end
      cnt++;
    end
    if (!seen_flag) fail_now("conflict_ready_timeout");
`ifdef VMEM_STORE_XBAR_SERIALIZE_EN
    check("conflict_ready_low_cycles", MW'(cnt), MW'(2));
`else
    check("conflict_ready_low_cycles", MW'(cnt), MW'(0));
`endif
    @(posedge clk); #1;
    wait_idle();
    check("conflict_slot3_final", MW'(mem_dut[3]), MW'(8'hA9));

    // Backpressure: beat must sit frozen while out_ready is low.
    ready_mode = 2;
    @(posedge clk); #2;
    send(id_en, id_sel, id_data, acc_a);
    seen_flag = 0;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      if (out_valid) begin seen_flag = 1; break; end
    end
    if (!seen_flag) fail_now("bp_valid_timeout");
    nbefore = hs_count;
    for (int k = 0; k < 4; k++) begin
      check("bp_valid", MW'(out_valid), MW'(1));
      check("bp_data", out_data, id_line);
      check("bp_busy", MW'(busy), MW'(1));
      @(negedge clk);
    end
    check("bp_no_handshake", MW'(hs_count), MW'(nbefore));
    ready_mode = 0;
    seen_flag = 0;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk); #1;
      if (hs_count > nbefore) begin seen_flag = 1; break; end
    end
    if (!seen_flag) fail_now("bp_release_timeout");
    @(posedge clk); #1;
    wait_idle();

    // Back-to-back conflict-free requests (rotated permutations).
    for (int i = 0; i < NL; i++) begin
      r_sel[i*SW +: SW] = SW'((i + 5) % NS);
      cf_sel[i*SW +: SW] = SW'((i + 11) % NS);
    end
    hs0 = hs_count;
    send('1, r_sel, {$urandom, $urandom, $urandom, $urandom}, acc_a);
    send('1, cf_sel, {$urandom, $urandom, $urandom, $urandom}, acc_b);
    check("b2b_accept_gap", MW'(acc_b - acc_a), MW'(1));
    wait_idle();
    check("b2b_beat_count", MW'(hs_count - hs0), MW'(2));
    if (hs_cyc.size() >= 2)
      check("b2b_beat_gap", MW'(hs_cyc[hs_cyc.size()-1] - hs_cyc[hs_cyc.size()-2]), MW'(1));

    // Empty request.
    nbefore = hs_count;
    send('0, {$urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, acc_a);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("empty_valid", MW'(out_valid), MW'(0));
      check("empty_busy", MW'(busy), MW'(0));
    end
    check("empty_no_beat", MW'(hs_count), MW'(nbefore));
    @(posedge clk); #1;

    // Reset while the conflict request is mid-flight.
    nbefore = hs_count;
    send(cf_en, {cf_sel[SW*NL-1:0]} & '0 | {16{4'd3}}, cf_data, acc_a);
    seen_flag = 0;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk); #1;
      if (hs_count > nbefore) begin seen_flag = 1; break; end
    end
    if (!seen_flag) fail_now("reset_first_beat_timeout");
    #1;
    resetn = 1'b0;
    #1;
    check_reset_outputs("midreset");
    exp_q.delete();
    clear_mems();
    @(posedge clk); #1;
    resetn = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("post_reset_valid", MW'(out_valid), MW'(0));
      check("post_reset_busy", MW'(busy), MW'(0));
    end
    @(posedge clk); #1;

    // Randomized traffic with random backpressure.
    ready_mode = 1;
    for (int n = 0; n < 150; n++) begin
      case ($urandom_range(0, 7))
        0:       r_en = '0;
        1:       r_en = '1;
        default: r_en = NL'($urandom);
      endcase
      for (int i = 0; i < NL; i++)
        r_sel[i*SW +: SW] = (n % 3 == 0) ? SW'($urandom_range(0, 3)) : SW'($urandom_range(0, NS - 1));
      r_data = {$urandom, $urandom, $urandom, $urandom};
      send(r_en, r_sel, r_data, acc_a);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    ready_mode = 0;
    @(posedge clk); #2;
    wait_idle();
    for (int s = 0; s < NS; s++)
      check($sformatf("final_mem_slot%0d", s), MW'(mem_dut[s]), MW'(mem_ref[s]));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    failures++;
    $display("FAIL global_timeout actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
